// File: rtl/dma_timing_ctrl_if.sv
// Handshake and bus bundle between the priority stage, the channel register
// file and the 8237A-style timing/control state machine.
interface dma_timing_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              dreq_valid;
  logic [1:0]        grant_ch;
  logic [1:0]        mode_type;
  logic [1:0]        mode_sel;
  logic              mode_dec;
  logic              mode_autoinit;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  cur_count;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  base_count;
  logic              HLDA;
  logic              EOP_N_in;

  logic              HRQ;
  logic              AEN;
  logic              ADSTB;
  logic [1:0]        dack_valid;
  logic [1:0]        dack_ch;
  logic [ADDR_W-1:0] addr_out;
  logic              MEMR_N;
  logic              MEMW_N;
  logic              IOR_N;
  logic              IOW_N;
  logic              EOP_N_out;
  logic              wb_en;
  logic [1:0]        wb_ch;
  logic [ADDR_W-1:0] wb_addr;
  logic [CNT_W-1:0]  wb_count;
  logic [3:0]        tc_set;
  logic [3:0]        req_clr;
  logic [3:0]        mask_set;

  modport master (
    input  dreq_valid, grant_ch, mode_type, mode_sel, mode_dec, mode_autoinit,
           cur_addr, cur_count, base_addr, base_count, HLDA, EOP_N_in,
    output HRQ, AEN, ADSTB, dack_valid, dack_ch, addr_out,
           MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out,
           wb_en, wb_ch, wb_addr, wb_count, tc_set, req_clr, mask_set
  );

  modport slave (
    output dreq_valid, grant_ch, mode_type, mode_sel, mode_dec, mode_autoinit,
           cur_addr, cur_count, base_addr, base_count, HLDA, EOP_N_in,
    input  HRQ, AEN, ADSTB, dack_valid, dack_ch, addr_out,
           MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out,
           wb_en, wb_ch, wb_addr, wb_count, tc_set, req_clr, mask_set
  );
endinterface

// File: rtl/dma_timing_ctrl.sv
// 8237A-style DMA timing/control FSM: HRQ/HLDA handshake, SI..S4 transfer
// sequencing, address/count write-back and TC/EOP reporting.
module dma_timing_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input logic               CLK,
  input logic               RESET,
  dma_timing_ctrl_if.master bus
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4, CASC} state_t;

  localparam logic [1:0] SEL_DEMAND  = 2'b00;
  localparam logic [1:0] SEL_SINGLE  = 2'b01;
  localparam logic [1:0] SEL_BLOCK   = 2'b10;
  localparam logic [1:0] SEL_CASCADE = 2'b11;

  state_t            stateQ;
  logic [1:0]        chQ, typeQ, selQ;
  logic              decQ, autoQ;
  logic [ADDR_W-1:0] addrQ, addrOutQ, wbAddrQ;
  logic [CNT_W-1:0]  cntQ, wbCountQ;
  logic              eopQ, tcQ, samePageQ;
  logic              hrqQ, aenQ, adstbQ, dackQ, wbEnQ, eopOutQ;
  logic              memrQ, memwQ, iorQ, iowQ;
  logic [1:0]        wbChQ;
  logic [3:0]        tcSetQ, reqClrQ, maskSetQ;

  logic              isRead, isWrite, isTc, eopSeen, samePage, burstOn;
  logic [ADDR_W-1:0] stepAddr, newAddr;
  logic [CNT_W-1:0]  stepCnt, newCnt;
  logic [3:0]        chBit;

  // Per-transfer arithmetic on the working registers; autoinit reloads on TC
  always_comb begin
    isRead   = (typeQ == 2'b10);
    isWrite  = (typeQ == 2'b01);
    chBit    = 4'b0001 << chQ;
    stepAddr = decQ ? (addrQ - ADDR_W'(1)) : (addrQ + ADDR_W'(1));
    stepCnt  = cntQ - CNT_W'(1);
    isTc     = (cntQ == '0);
    newAddr  = (isTc && autoQ) ? bus.base_addr  : stepAddr;
    newCnt   = (isTc && autoQ) ? bus.base_count : stepCnt;
    samePage = (stepAddr[ADDR_W-1:8] == addrQ[ADDR_W-1:8]);
    eopSeen  = eopQ | ~bus.EOP_N_in;
    burstOn  = (selQ == SEL_BLOCK) ||
               ((selQ == SEL_DEMAND) && bus.dreq_valid && (bus.grant_ch == chQ));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateQ    <= SI;
      chQ       <= '0;
      typeQ     <= '0;
      selQ      <= '0;
      decQ      <= 1'b0;
      autoQ     <= 1'b0;
      addrQ     <= '0;
      cntQ      <= '0;
      eopQ      <= 1'b0;
      tcQ       <= 1'b0;
      samePageQ <= 1'b0;
      hrqQ      <= 1'b0;
      aenQ      <= 1'b0;
      adstbQ    <= 1'b0;
      dackQ     <= 1'b0;
      wbEnQ     <= 1'b0;
      eopOutQ   <= 1'b1;
      memrQ     <= 1'b1;
      memwQ     <= 1'b1;
      iorQ      <= 1'b1;
      iowQ      <= 1'b1;
      addrOutQ  <= '0;
      wbChQ     <= '0;
      wbAddrQ   <= '0;
      wbCountQ  <= '0;
      tcSetQ    <= '0;
      reqClrQ   <= '0;
      maskSetQ  <= '0;
    end else begin
      wbEnQ    <= 1'b0;
      eopOutQ  <= 1'b1;
      tcSetQ   <= '0;
      reqClrQ  <= '0;
      maskSetQ <= '0;
      case (stateQ)
        SI: begin
          if (bus.dreq_valid) begin
            stateQ <= S0;
            hrqQ   <= 1'b1;
            chQ    <= bus.grant_ch;
            typeQ  <= bus.mode_type;
            selQ   <= bus.mode_sel;
            decQ   <= bus.mode_dec;
            autoQ  <= bus.mode_autoinit;
            eopQ   <= 1'b0;
          end
        end
        S0: begin
          if (bus.HLDA) begin
            if (selQ == SEL_CASCADE) begin
              stateQ <= CASC;
              dackQ  <= 1'b1;
            end else begin
              stateQ   <= S1;
              addrQ    <= bus.cur_addr;
              cntQ     <= bus.cur_count;
              addrOutQ <= bus.cur_addr;
              aenQ     <= 1'b1;
              adstbQ   <= 1'b1;
              dackQ    <= 1'b1;
            end
          end else if (!bus.dreq_valid) begin
            stateQ <= SI;
            hrqQ   <= 1'b0;
          end
        end
        CASC: begin
          if (!bus.dreq_valid) begin
            stateQ <= SI;
            hrqQ   <= 1'b0;
            dackQ  <= 1'b0;
          end
        end
        S1: begin
          stateQ <= S2;
          adstbQ <= 1'b0;
          memrQ  <= ~isRead;
          iorQ   <= ~isWrite;
          eopQ   <= eopSeen;
        end
        S2: begin
          stateQ <= S3;
          memwQ  <= ~isWrite;
          iowQ   <= ~isRead;
          eopQ   <= eopSeen;
        end
        // Write-back values and TC pulses are registered here so they line up with S4
        S3: begin
          stateQ    <= S4;
          memrQ     <= 1'b1;
          memwQ     <= 1'b1;
          iorQ      <= 1'b1;
          iowQ      <= 1'b1;
          wbEnQ     <= 1'b1;
          wbChQ     <= chQ;
          wbAddrQ   <= newAddr;
          wbCountQ  <= newCnt;
          addrQ     <= newAddr;
          cntQ      <= newCnt;
          tcQ       <= isTc;
          samePageQ <= samePage;
          eopQ      <= eopSeen;
          if (isTc) begin
            eopOutQ <= 1'b0;
            tcSetQ  <= chBit;
            reqClrQ <= chBit;
            if (!autoQ) maskSetQ <= chBit;
          end else if (eopSeen) begin
            reqClrQ <= chBit;
          end
        end
        S4: begin
          if (tcQ || eopSeen || !bus.HLDA || !burstOn) begin
            stateQ <= SI;
            hrqQ   <= 1'b0;
            aenQ   <= 1'b0;
            dackQ  <= 1'b0;
            eopQ   <= 1'b0;
          end else if (samePageQ) begin
            stateQ   <= S2;
            memrQ    <= ~isRead;
            iorQ     <= ~isWrite;
            addrOutQ <= addrQ;
          end else begin
            stateQ   <= S1;
            adstbQ   <= 1'b1;
            addrOutQ <= addrQ;
          end
        end
        default: begin
          stateQ <= SI;
          hrqQ   <= 1'b0;
          aenQ   <= 1'b0;
          adstbQ <= 1'b0;
          dackQ  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HRQ        = hrqQ;
  assign bus.AEN        = aenQ;
  assign bus.ADSTB      = adstbQ;
  assign bus.dack_valid = {1'b0, dackQ};
  assign bus.dack_ch    = chQ;
  assign bus.addr_out   = addrOutQ;
  assign bus.MEMR_N     = memrQ;
  assign bus.MEMW_N     = memwQ;
  assign bus.IOR_N      = iorQ;
  assign bus.IOW_N      = iowQ;
  assign bus.EOP_N_out  = eopOutQ;
  assign bus.wb_en      = wbEnQ;
  assign bus.wb_ch      = wbChQ;
  assign bus.wb_addr    = wbAddrQ;
  assign bus.wb_count   = wbCountQ;
  assign bus.tc_set     = tcSetQ;
  assign bus.req_clr    = reqClrQ;
  assign bus.mask_set   = maskSetQ;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Self-checking bench for dma_timing_ctrl: directed transfer scenarios plus
// randomized bursts compared against a transfer-level reference model.
module tb_dma_timing_ctrl;

  localparam int AW = 16;
  localparam int CW = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dma_timing_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
  dma_timing_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] addr;
    logic [15:0] cnt;
    logic [3:0]  tcSet;
    logic [3:0]  reqClr;
    logic [3:0]  maskSet;
    logic        eopLow;
    logic [3:0]  memr;
    logic [3:0]  memw;
    logic [3:0]  ior;
    logic [3:0]  iow;
  } wbRec_t;

  wbRec_t      wbLog[$];
  logic [15:0] adstbLog[$];
  wbRec_t      expWb[$];
  logic [15:0] expAdstb[$];
  logic [3:0]  memrCnt, memwCnt, iorCnt, iowCnt;
  int          testsRun = 0;
  int          testsFailed = 0;

  // Bus monitor: logs every address strobe and every write-back with the strobe activity of its transfer
  always @(negedge CLK) begin : monitor
    wbRec_t r;
    if (RESET) begin
      memrCnt = '0; memwCnt = '0; iorCnt = '0; iowCnt = '0;
    end else begin
      if (bus.ADSTB) adstbLog.push_back(bus.addr_out);
      if (!bus.MEMR_N) memrCnt++;
      if (!bus.MEMW_N) memwCnt++;
      if (!bus.IOR_N)  iorCnt++;
      if (!bus.IOW_N)  iowCnt++;
      if (bus.wb_en) begin
        r = '{ch: bus.wb_ch, addr: bus.wb_addr, cnt: bus.wb_count, tcSet: bus.tc_set,
              reqClr: bus.req_clr, maskSet: bus.mask_set, eopLow: ~bus.EOP_N_out,
              memr: memrCnt, memw: memwCnt, ior: iorCnt, iow: iowCnt};
        wbLog.push_back(r);
        memrCnt = '0; memwCnt = '0; iorCnt = '0; iowCnt = '0;
      end
    end
  end

  function automatic wbRec_t getWb(input int idx);
    wbRec_t r;
    r = '0;
    if (idx < wbLog.size()) r = wbLog[idx];
    return r;
  endfunction

  function automatic logic [15:0] getAd(input int idx);
    logic [15:0] a;
    a = 16'hxxxx;
    if (idx < adstbLog.size()) a = adstbLog[idx];
    return a;
  endfunction

  task automatic applyStimulus(input logic [1:0] ch, input logic [1:0] typ, input logic [1:0] sel,
                               input logic dec, input logic auto, input logic [15:0] a,
                               input logic [15:0] c, input logic [15:0] ba, input logic [15:0] bc);
    bus.grant_ch = ch;   bus.mode_type = typ;  bus.mode_sel = sel;
    bus.mode_dec = dec;  bus.mode_autoinit = auto;
    bus.cur_addr = a;    bus.cur_count = c;
    bus.base_addr = ba;  bus.base_count = bc;
    bus.EOP_N_in = 1'b1;
  endtask

  // Raise the request, grant HLDA after a delay, optionally pulse EOP in S2, wait for HRQ to drop
  task automatic runBurst(input int hldaDelay, input bit eopInS2);
    int guard;
    bus.dreq_valid = 1'b1;
    guard = 0;
    while (bus.HRQ !== 1'b1 && guard < 20) begin @(negedge CLK); guard++; end
    testsRun++;
    if (bus.HRQ !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hrq_rise: HRQ=%b required 1", bus.HRQ);
    end
    repeat (hldaDelay) @(negedge CLK);
    bus.HLDA = 1'b1;
    @(negedge CLK);
    bus.cur_addr  = 16'($urandom);
    bus.cur_count = 16'($urandom);
    if (eopInS2) begin
      @(negedge CLK);
      bus.EOP_N_in = 1'b0;
      @(negedge CLK);
      bus.EOP_N_in = 1'b1;
    end
    guard = 0;
    while (bus.HRQ === 1'b1 && guard < 200) begin @(negedge CLK); guard++; end
    bus.dreq_valid = 1'b0;
    bus.HLDA = 1'b0;
    testsRun++;
    if (bus.HRQ !== 1'b0 || bus.dack_valid !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL burst_end: HRQ=%b dack_valid=%b required 0/00", bus.HRQ, bus.dack_valid);
    end
    @(negedge CLK);
  endtask

  // Transfer-level reference: one record per transfer, stopping on TC or after one single-mode transfer
  task automatic modelBurst(input logic [1:0] ch, input logic [1:0] typ, input logic [1:0] sel,
                            input logic dec, input logic auto, input logic [15:0] a0,
                            input logic [15:0] c0, input logic [15:0] ba, input logic [15:0] bc);
    logic [15:0] a, c, na;
    logic [7:0]  prevPage;
    logic        tc;
    wbRec_t      r;
    expWb.delete();
    expAdstb.delete();
    a = a0; c = c0; prevPage = 8'h00;
    for (int k = 0; k < 100; k++) begin
      if (k == 0 || a[15:8] != prevPage) expAdstb.push_back(a);
      tc = (c == 16'h0000);
      na = dec ? a - 16'd1 : a + 16'd1;
      r = '0;
      r.ch      = ch;
      r.addr    = (tc && auto) ? ba : na;
      r.cnt     = (tc && auto) ? bc : c - 16'd1;
      r.tcSet   = tc ? (4'b0001 << ch) : 4'b0000;
      r.reqClr  = tc ? (4'b0001 << ch) : 4'b0000;
      r.maskSet = (tc && !auto) ? (4'b0001 << ch) : 4'b0000;
      r.eopLow  = tc;
      if (typ == 2'b10) begin r.memr = 4'd2; r.iow = 4'd1; end
      if (typ == 2'b01) begin r.ior = 4'd2; r.memw = 4'd1; end
      expWb.push_back(r);
      if (tc || sel == 2'b01) break;
      prevPage = a[15:8];
      a = na;
      c = c - 16'd1;
    end
  endtask

  task automatic test_reset();
    testsRun++;
    if ({bus.HRQ, bus.AEN, bus.ADSTB, bus.dack_valid, bus.wb_en} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: HRQ/AEN/ADSTB/dack/wb_en=%b required 000000",
               {bus.HRQ, bus.AEN, bus.ADSTB, bus.dack_valid, bus.wb_en});
    end
    testsRun++;
    if ({bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.EOP_N_out} !== 5'b11111) begin
      testsFailed++;
      $display("[TB] FAIL reset_strobes: got %b required 11111",
               {bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.EOP_N_out});
    end
    testsRun++;
    if ({bus.tc_set, bus.req_clr, bus.mask_set, bus.addr_out} !== 28'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pulses_addr: got %h required 0",
               {bus.tc_set, bus.req_clr, bus.mask_set, bus.addr_out});
    end
  endtask

  task automatic test_single_read();
    int w0, a0;
    wbRec_t r;
    w0 = wbLog.size(); a0 = adstbLog.size();
    applyStimulus(2'd1, 2'b10, 2'b01, 1'b0, 1'b0, 16'h1234, 16'h0002, 16'h0000, 16'h0000);
    runBurst(2, 1'b0);
    r = getWb(w0);
    testsRun++;
    if (wbLog.size() - w0 != 1 || adstbLog.size() - a0 != 1 || getAd(a0) !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL single_read_adstb: wb=%0d adstb=%0d addr=%h required 1/1/1234",
               wbLog.size() - w0, adstbLog.size() - a0, getAd(a0));
    end
    testsRun++;
    if ({r.ch, r.addr, r.cnt} !== {2'd1, 16'h1235, 16'h0001}) begin
      testsFailed++;
      $display("[TB] FAIL single_read_wb: ch=%0d addr=%h cnt=%h required 1/1235/0001", r.ch, r.addr, r.cnt);
    end
    testsRun++;
    if ({r.memr, r.memw, r.ior, r.iow} !== 16'h2001 || r.tcSet !== 4'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_read_strobes: memr/memw/ior/iow=%h tc=%b required 2001/0000",
               {r.memr, r.memw, r.ior, r.iow}, r.tcSet);
    end
  endtask

  task automatic test_block_write_tc();
    int w0, a0;
    wbRec_t r0, r1;
    w0 = wbLog.size(); a0 = adstbLog.size();
    applyStimulus(2'd2, 2'b01, 2'b10, 1'b0, 1'b0, 16'h00FE, 16'h0001, 16'h0000, 16'h0000);
    runBurst(1, 1'b0);
    r0 = getWb(w0); r1 = getWb(w0 + 1);
    testsRun++;
    if (wbLog.size() - w0 != 2 || adstbLog.size() - a0 != 1) begin
      testsFailed++;
      $display("[TB] FAIL block_write_count: wb=%0d adstb=%0d required 2/1",
               wbLog.size() - w0, adstbLog.size() - a0);
    end
    testsRun++;
    if ({r1.addr, r1.cnt, r1.eopLow, r0.eopLow} !== {16'h0100, 16'hFFFF, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL block_write_tc_wb: addr=%h cnt=%h eop=%b/%b required 0100/FFFF/1/0",
               r1.addr, r1.cnt, r1.eopLow, r0.eopLow);
    end
    testsRun++;
    if ({r1.tcSet, r1.maskSet, r1.reqClr} !== 12'b0100_0100_0100 || {r1.memr, r1.memw, r1.ior, r1.iow} !== 16'h0120) begin
      testsFailed++;
      $display("[TB] FAIL block_write_pulses: tc/mask/req=%b strobes=%h required 010001000100/0120",
               {r1.tcSet, r1.maskSet, r1.reqClr}, {r1.memr, r1.memw, r1.ior, r1.iow});
    end
  endtask

  task automatic test_autoinit();
    int w0;
    wbRec_t r;
    w0 = wbLog.size();
    applyStimulus(2'd0, 2'b10, 2'b10, 1'b0, 1'b1, 16'h2222, 16'h0000, 16'h4000, 16'h0010);
    runBurst(0, 1'b0);
    r = getWb(w0);
    testsRun++;
    if (wbLog.size() - w0 != 1 || {r.addr, r.cnt} !== {16'h4000, 16'h0010}) begin
      testsFailed++;
      $display("[TB] FAIL autoinit_wb: n=%0d addr=%h cnt=%h required 1/4000/0010",
               wbLog.size() - w0, r.addr, r.cnt);
    end
    testsRun++;
    if ({r.tcSet, r.maskSet, r.reqClr, r.eopLow} !== 13'b0001_0000_0001_1) begin
      testsFailed++;
      $display("[TB] FAIL autoinit_pulses: tc/mask/req/eop=%b required 0001000000011",
               {r.tcSet, r.maskSet, r.reqClr, r.eopLow});
    end
  endtask

  task automatic test_decrement_page();
    int w0, a0;
    w0 = wbLog.size(); a0 = adstbLog.size();
    applyStimulus(2'd3, 2'b00, 2'b10, 1'b1, 1'b0, 16'h0100, 16'h0003, 16'h0000, 16'h0000);
    runBurst(1, 1'b0);
    testsRun++;
    if (adstbLog.size() - a0 != 2 || getAd(a0 + 1) !== 16'h00FF || wbLog.size() - w0 != 4) begin
      testsFailed++;
      $display("[TB] FAIL decrement_page: adstb=%0d second=%h wb=%0d required 2/00FF/4",
               adstbLog.size() - a0, getAd(a0 + 1), wbLog.size() - w0);
    end
    testsRun++;
    if (getWb(w0 + 2).addr !== 16'h00FD || getWb(w0 + 3).cnt !== 16'hFFFF) begin
      testsFailed++;
      $display("[TB] FAIL decrement_wb: addr3=%h cnt4=%h required 00FD/FFFF",
               getWb(w0 + 2).addr, getWb(w0 + 3).cnt);
    end
  endtask

  task automatic test_ext_eop();
    int w0;
    wbRec_t r;
    w0 = wbLog.size();
    applyStimulus(2'd3, 2'b10, 2'b10, 1'b0, 1'b0, 16'h3000, 16'h0005, 16'h0000, 16'h0000);
    runBurst(1, 1'b1);
    r = getWb(w0);
    testsRun++;
    if (wbLog.size() - w0 != 1 || {r.addr, r.cnt} !== {16'h3001, 16'h0004}) begin
      testsFailed++;
      $display("[TB] FAIL ext_eop_wb: n=%0d addr=%h cnt=%h required 1/3001/0004",
               wbLog.size() - w0, r.addr, r.cnt);
    end
    testsRun++;
    if ({r.reqClr, r.tcSet, r.maskSet, r.eopLow} !== 13'b1000_0000_0000_0) begin
      testsFailed++;
      $display("[TB] FAIL ext_eop_pulses: req/tc/mask/eop=%b required 1000000000000",
               {r.reqClr, r.tcSet, r.maskSet, r.eopLow});
    end
  endtask

  task automatic test_cascade();
    int guard;
    applyStimulus(2'd3, 2'b00, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    bus.dreq_valid = 1'b1;
    guard = 0;
    while (bus.HRQ !== 1'b1 && guard < 20) begin @(negedge CLK); guard++; end
    bus.HLDA = 1'b1;
    repeat (2) @(negedge CLK);
    testsRun++;
    if ({bus.HRQ, bus.AEN, bus.dack_valid, bus.dack_ch, bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N} !== 10'b1_0_01_11_1111) begin
      testsFailed++;
      $display("[TB] FAIL cascade_active: HRQ/AEN/dack/ch/strobes=%b required 1001111111",
               {bus.HRQ, bus.AEN, bus.dack_valid, bus.dack_ch, bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N});
    end
    bus.dreq_valid = 1'b0;
    @(negedge CLK);
    bus.HLDA = 1'b0;
    testsRun++;
    if ({bus.HRQ, bus.dack_valid} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL cascade_exit: HRQ/dack=%b required 000", {bus.HRQ, bus.dack_valid});
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_transfer();
    int guard;
    applyStimulus(2'd0, 2'b10, 2'b10, 1'b0, 1'b0, 16'h2000, 16'h0005, 16'h0000, 16'h0000);
    bus.dreq_valid = 1'b1;
    guard = 0;
    while (bus.HRQ !== 1'b1 && guard < 20) begin @(negedge CLK); guard++; end
    bus.HLDA = 1'b1;
    guard = 0;
    while (bus.MEMR_N !== 1'b0 && guard < 20) begin @(negedge CLK); guard++; end
    testsRun++;
    if (bus.MEMR_N !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_reach_s2: MEMR_N=%b required 0", bus.MEMR_N);
    end
    #1 RESET = 1'b1;
    #1;
    testsRun++;
    if ({bus.MEMR_N, bus.HRQ, bus.dack_valid, bus.AEN} !== 5'b1_0_00_0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_async: MEMR_N/HRQ/dack/AEN=%b required 10000",
               {bus.MEMR_N, bus.HRQ, bus.dack_valid, bus.AEN});
    end
    @(negedge CLK);
    bus.dreq_valid = 1'b0;
    bus.HLDA = 1'b0;
    bus.mode_sel = 2'b00;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    testsRun++;
    if ({bus.HRQ, bus.AEN, bus.dack_valid} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle_after: HRQ/AEN/dack=%b required 0000", {bus.HRQ, bus.AEN, bus.dack_valid});
    end
  endtask

  task automatic test_random_bursts();
    logic [1:0]  ch, typ, sel;
    logic        dec, auto;
    logic [15:0] a, c, ba, bc;
    int          w0, a0, nWb, nAd;
    for (int it = 0; it < 25; it++) begin
      ch   = 2'($urandom_range(0, 3));
      typ  = 2'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 2));
      dec  = 1'($urandom_range(0, 1));
      auto = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[7:0] = dec ? 8'($urandom_range(0, 2)) : 8'(8'hFD + 8'($urandom_range(0, 2)));
      c    = 16'($urandom_range(0, 4));
      ba   = 16'($urandom);
      bc   = 16'($urandom);
      modelBurst(ch, typ, sel, dec, auto, a, c, ba, bc);
      w0 = wbLog.size(); a0 = adstbLog.size();
      applyStimulus(ch, typ, sel, dec, auto, a, c, ba, bc);
      runBurst($urandom_range(0, 3), 1'b0);
      nWb = wbLog.size() - w0;
      nAd = adstbLog.size() - a0;
      testsRun++;
      if (nWb != expWb.size() || nAd != expAdstb.size()) begin
        testsFailed++;
        $display("[TB] FAIL random_counts it=%0d: wb=%0d adstb=%0d required %0d/%0d",
                 it, nWb, nAd, expWb.size(), expAdstb.size());
      end
      for (int i = 0; i < expWb.size() && i < nWb; i++) begin
        testsRun++;
        if (getWb(w0 + i) !== expWb[i]) begin
          testsFailed++;
          $display("[TB] FAIL random_wb it=%0d xfer=%0d: got %h required %h", it, i, getWb(w0 + i), expWb[i]);
        end
      end
      for (int i = 0; i < expAdstb.size() && i < nAd; i++) begin
        testsRun++;
        if (getAd(a0 + i) !== expAdstb[i]) begin
          testsFailed++;
          $display("[TB] FAIL random_adstb it=%0d idx=%0d: got %h required %h", it, i, getAd(a0 + i), expAdstb[i]);
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.dreq_valid = 1'b0;
    bus.HLDA = 1'b0;
    applyStimulus(2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge CLK);
    test_reset();
    RESET = 1'b0;
    @(negedge CLK);
    test_single_read();
    test_block_write_tc();
    test_autoinit();
    test_decrement_page();
    test_ext_eop();
    test_cascade();
    test_random_bursts();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/dma_timing_ctrl.md
Name: dma_timing_ctrl

Overview:
- Timing and control state machine for the 8237A-style DMA controller, directly downstream of the priority encoder.
- Consumes the valid request and winning channel from the priority stage, and runs the HRQ/HLDA bus handshake.
- Sequences the SI/S0/S1/S2/S3/S4 transfer states, driving address, strobes and DACK.
- Updates the channel's current address and word count, and reports terminal count (TC) and EOP back to the channel register file.

Parameters:
ADDR_W, 16, address width (current/base address)
CNT_W, 16, word-count width

Ports:
CLK  in  1  system clock
RESET  in  1  reset, asynchronous, active-high
dreq_valid  in  1  any valid unmasked request from the priority stage
grant_ch  in  2  channel selected by the priority stage
mode_type  in  2  00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 treated as verify
mode_sel  in  2  00 demand, 01 single, 10 block, 11 cascade
mode_dec  in  1  1 = address decrement, 0 = increment
mode_autoinit  in  1  autoinitialize on TC
cur_addr  in  ADDR_W  current address of grant_ch
cur_count  in  CNT_W  current word count of grant_ch
base_addr  in  ADDR_W  base address of grant_ch
base_count  in  CNT_W  base word count of grant_ch
HLDA  in  1  hold acknowledge from CPU
EOP_N_in  in  1  external end-of-process, active-low
HRQ  out  1  hold request
AEN  out  1  address enable
ADSTB  out  1  upper-address strobe
dack_valid  out  2  dack_valid=active-channel DACK request (bit0), dack_ch not used
dack_ch  out  2  active channel
addr_out  out  ADDR_W  transfer address
MEMR_N, MEMW_N, IOR_N, IOW_N  out  1 each  bus strobes, active-low
EOP_N_out  out  1  internal TC indication, active-low
wb_en  out  1  write-back strobe to the channel registers
wb_ch  out  2  write-back channel
wb_addr  out  ADDR_W  new current address
wb_count  out  CNT_W  new current count
tc_set  out  4  one-hot pulse, sets the status TC bit
req_clr  out  4  one-hot pulse, clears the software request bit
mask_set  out  4  one-hot pulse, sets the mask bit on TC without autoinit

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=SI; HRQ, AEN, ADSTB, dack_valid, wb_en=0.
  - All strobes=1; EOP_N_out=1; tc_set/req_clr/mask_set=0; addr_out=0.
- All outputs are registered from state.
- SI -> S0 when dreq_valid=1:
  - Latch grant_ch and all mode fields into active registers.
  - HRQ=1 from the next cycle.
- S0:
  - Wait for HLDA.
  - If dreq_valid drops before HLDA: -> SI, HRQ=0.
  - HLDA=1 and cascade: -> CASC.
  - HLDA=1 otherwise: -> S1, latching cur_addr/cur_count into working registers.
- CASC:
  - dack_valid=1, HRQ=1; AEN=0, no strobes.
  - Exit to SI when dreq_valid=0.
- S1: AEN=1, ADSTB=1, addr_out=working addr, dack_valid=1.
- S2: AEN=1, dack_valid=1, ADSTB=0.
  - read: MEMR_N=0. write: IOR_N=0. verify: no strobes.
- S3: read strobe held.
  - read: IOW_N=0. write: MEMW_N=0.
- S4 (one cycle): all strobes=1, dack_valid=1.
  - wb_en=1, wb_ch=active channel.
  - wb_addr = addr±1 (wraps mod 2^ADDR_W).
  - wb_count = count-1 (wraps mod 2^CNT_W).
  - Working registers update to the same values.
- TC = working count equal to 0 at S4 (count wraps 0->all-ones). On TC in S4:
  - EOP_N_out=0 for that cycle; tc_set[ch]=1; req_clr[ch]=1.
  - If autoinit: wb_addr=base_addr, wb_count=base_count, no mask.
  - Else: mask_set[ch]=1.
- External EOP:
  - EOP_N_in sampled low in any of S1..S4 is latched.
  - The current transfer completes S4 normally: write-back, req_clr[ch]=1, no tc_set.
  - Then -> SI.
- S4 next state, first match:
  - TC or latched EOP or HLDA=0: -> SI, HRQ=0.
  - single: -> SI, HRQ=0; a new request goes through S0 again.
  - block: -> S2 if the new addr[ADDR_W-1:8] equals the old one, else -> S1.
  - demand: same as block while dreq_valid=1 and grant_ch is unchanged, else -> SI.
- HLDA dropping in S1..S3 does not abort; the transfer finishes through S4, then -> SI.
- The cur_* inputs are ignored during a burst; the working registers are authoritative.

Test Plan:
1. Single read, ch1, cur_addr=0x1234, cur_count=0x0002, HLDA 2 cycles after HRQ -> S1 with ADSTB=1, addr_out=0x1234; MEMR_N=0 in S2-S3; IOW_N=0 in S3; S4 wb_addr=0x1235, wb_count=0x0001, wb_ch=1; then SI with HRQ=0.
2. Block write, ch2, addr 0x00FE, count 0x0001, increment -> second transfer skips S1; S4 of transfer 2 gives wb_count=0xFFFF, EOP_N_out low one cycle, tc_set=mask_set=req_clr=4'b0100; then SI.
3. Block, ch0, autoinit, count 0x0000, base_addr=0x4000, base_count=0x0010 -> TC on first transfer: wb_addr=0x4000, wb_count=0x0010, mask_set=0, tc_set=4'b0001.
4. Block, decrement, addr 0x0100, count 0x0003 -> transfer 2 goes through S1 with ADSTB=1 and addr_out=0x00FF; transfer 3 (0x00FE) skips S1.
5. Block read, count 0x0005, EOP_N_in low in S2 of the first transfer -> S4 wb_count=0x0004, req_clr=1, tc_set=0; then SI with HRQ=0.
6. RESET asserted mid-S2 of a read -> MEMR_N=1, HRQ=0, dack_valid=0 without waiting for CLK; after release, demand-mode dreq_valid=0 leaves the block in SI.
